// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: shared shift-add / restoring-divide datapath, one step per cycle.
// Optional MULDIV_FASTPATH_EN: corner cases (div by zero, signed overflow, zero multiply) finish from IDLE.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_m, r_result;
  logic [W2-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sa, r_sb, r_dz, r_ovf, r_busy, r_valid;

  // Signedness and magnitudes of the incoming operands
  logic             w_is_div, w_a_signed, w_b_signed, w_sa, w_sb, w_dz, w_ovf, w_accept;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  assign w_is_div   = op_i[2];
  assign w_a_signed = w_is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~op_i[0] : ~op_i[1];
  assign w_sa       = w_a_signed & a_i[WIDTH-1];
  assign w_sb       = w_b_signed & b_i[WIDTH-1];
  assign w_abs_a    = w_sa ? -a_i : a_i;
  assign w_abs_b    = w_sb ? -b_i : b_i;
  assign w_dz       = (b_i == '0);
  assign w_ovf      = w_is_div & ~op_i[0] & (a_i == MIN_NEG) & (b_i == '1);
  assign w_accept   = (r_state == IDLE) & start_i & ~flush_i;

`ifdef MULDIV_FASTPATH_EN
  logic             w_corner;
  logic [WIDTH-1:0] w_corner_res;
  assign w_corner = w_is_div ? (w_dz | w_ovf) : ((a_i == '0) | (b_i == '0));
  always_comb begin
    w_corner_res = '0;
    if (w_is_div && w_dz)       w_corner_res = op_i[1] ? a_i : '1;
    else if (w_is_div && w_ovf) w_corner_res = op_i[1] ? '0 : a_i;
  end
`endif

  // One iteration: acc = {hi, lo}; multiply shifts right, divide shifts left
  logic [WIDTH:0]  w_mul_sum, w_div_tmp, w_div_diff;
  logic [W2-1:0]   w_step;
  assign w_mul_sum  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_div_tmp  = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff = w_div_tmp - {1'b0, r_m};
  always_comb begin
    w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (r_op[2]) begin
      if (!w_div_diff[WIDTH]) w_step = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else                    w_step = {w_div_tmp[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up, half selection and divide corner overrides
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo, w_rem, w_fix_res;
  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_sa ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];
  always_comb begin
    w_fix_res = r_op[1] ? w_rem : w_quo;
    if (!r_op[2])   w_fix_res = (r_op[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[W2-1:WIDTH];
    else if (r_dz)  w_fix_res = r_op[1] ? r_a : '1;
    else if (r_ovf) w_fix_res = r_op[1] ? '0 : r_a;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
`ifdef MULDIV_FASTPATH_EN
        w_state_nx = w_corner ? DONE : CALC;
`else
        w_state_nx = CALC;
`endif
      end
      CALC:    if (r_cnt == CNT_W'(1)) w_state_nx = FIX;
      FIX:     w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (flush_i) w_state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != IDLE);
      r_valid <= (w_state_nx == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= op_i;
      r_a   <= a_i;
      r_sa  <= w_sa;
      r_sb  <= w_sb;
      r_dz  <= w_dz;
      r_ovf <= w_ovf;
      r_m   <= w_is_div ? w_abs_b : w_abs_a;
      r_acc <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
      r_cnt <= CNT_W'(WIDTH);
`ifdef MULDIV_FASTPATH_EN
      if (w_corner) r_result <= w_corner_res;
`endif
    end else if (!flush_i && r_state == CALC) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (!flush_i && r_state == FIX) begin
      r_result <= w_fix_res;
    end
  end

  // Pipeline stall is combinational so the pipeline advances in the DONE cycle
  assign stall_o        = rst_n & start_i & ~r_valid & ~flush_i;
  assign busy_o         = r_busy;
  assign result_valid_o = r_valid;
  assign result_o       = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed table-driven bench for muldiv_sequencer, plus flush and mid-op reset sequences.
module tb_muldiv_sequencer;
  localparam int unsigned W        = 32;
  localparam int unsigned MAX_WAIT = 60;
  localparam int unsigned FULL_LAT = W + 2;
`ifdef MULDIV_FASTPATH_EN
  localparam int unsigned FAST_LAT = 1;
`else
  localparam int unsigned FAST_LAT = W + 2;
`endif
  localparam int unsigned NVEC = 22;

  logic         clk, rst_n, start_i, flush_i;
  logic [2:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         stall_o, busy_o, result_valid_o;
  logic [W-1:0] result_o;
  int           n_checks, n_fail;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    bit           corner;
  } vec_t;
  vec_t vecs[NVEC];

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o),
    .result_valid_o(result_valid_o), .result_o(result_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
  endtask

  // Holds start_i like a stalled pipeline; returns cycle of the strobe relative to issue
  task automatic wait_strobe(output logic [W-1:0] res, output int lat, output int nstall,
                             output logic stall_done);
    bit got;
    got = 1'b0; res = '0; lat = 0; nstall = 0; stall_done = 1'b1;
    while (!got && lat < int'(MAX_WAIT)) begin
      #1;
      if (result_valid_o) begin
        got        = 1'b1;
        res        = result_o;
        stall_done = stall_o;
      end else begin
        if (stall_o) nstall++;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  initial begin
    logic [W-1:0] res;
    int           lat, nst, strobes, busies, exp_lat;
    logic         sd;

    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'b111, 32'd5,         32'd0,         32'd5,         1'b1};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[12] = '{3'b000, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 1'b1};
    vecs[13] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b1};
    vecs[14] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[15] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[16] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[17] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[18] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[19] = '{3'b000, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0};
    vecs[20] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF, 1'b0};
    vecs[21] = '{3'b011, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b1};

    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset busy",   W'(busy_o),         '0);
    check("reset valid",  W'(result_valid_o), '0);
    check("reset stall",  W'(stall_o),        '0);
    check("reset result", result_o,           '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      exp_lat = vecs[i].corner ? int'(FAST_LAT) : int'(FULL_LAT);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_strobe(res, lat, nst, sd);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), W'(lat), W'(exp_lat));
      check($sformatf("vec%0d stall cycles", i), W'(nst), W'(exp_lat));
      check($sformatf("vec%0d stall in done", i), W'(sd), '0);
      // start_i was still high in the DONE cycle; it must not start a second op
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      #1;
      check($sformatf("vec%0d idle after done", i), W'({busy_o, result_valid_o}), '0);
    end

    // Flush a DIV at cycle 10, then issue MUL 3*4 at cycle 12
    issue(3'b100, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    #1;
    check("busy before flush", W'(busy_o), W'(1));
    flush_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("busy after flush",   W'(busy_o),         '0);
    check("no strobe on flush", W'(result_valid_o), '0);
    check("result held on flush", result_o, vecs[NVEC-1].exp);
    issue(3'b000, 32'd3, 32'd4);
    wait_strobe(res, lat, nst, sd);
    check("post-flush mul result", res, 32'd12);
    check("post-flush mul strobe cycle", W'(lat + 12), W'(46));
    @(negedge clk);
    start_i = 1'b0;

    // Reset asserted at cycle 5 of a MUL
    issue(3'b000, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    #1;
    check("busy before reset", W'(busy_o), W'(1));
    rst_n = 1'b0;
    #1;
    check("reset mid-op busy",   W'(busy_o),         '0);
    check("reset mid-op stall",  W'(stall_o),        '0);
    check("reset mid-op valid",  W'(result_valid_o), '0);
    check("reset mid-op result", result_o,           '0);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    strobes = 0;
    busies  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (result_valid_o) strobes++;
      if (busy_o) busies++;
    end
    check("strobes after reset release", W'(strobes), '0);
    check("busy after reset release",    W'(busies),  '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the RV32M multiply/divide operations in the EX stage. It accepts one M-extension op from the pipeline and stalls the pipeline while it iterates a shared shift-add / restoring-divide datapath. It applies the RISC-V sign and corner-case rules and returns a single-cycle result strobe. It sits beside the main ALU; the ALU control selects it when funct7 = 0000001 on R-type ops.

Parameters:
WIDTH, 32, operand/result width in bits; must be even and >= 8.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start_i  input  1  EX stage holds a valid M-extension op.
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
a_i  input  WIDTH  rs1 operand.
b_i  input  WIDTH  rs2 operand.
flush_i  input  1  pipeline flush; abort the current op.
stall_o  output  1  hold IF/ID/EX registers.
busy_o  output  1  FSM is not in IDLE.
result_valid_o  output  1  one-cycle strobe; result_o is valid this cycle.
result_o  output  WIDTH  rd write data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: FSM = IDLE; stall_o, busy_o, result_valid_o = 0; result_o = 0; counter = 0; internal operand/accumulator registers = 0.
- FSM states:
  - IDLE: start_i && !flush_i latches a_i, b_i, op_i, the sign flags and the absolute values of the operands (per op signedness), clears the accumulator, loads counter = WIDTH, and goes to CALC.
  - CALC: performs one multiply or divide step per cycle and decrements the counter. At counter == 1, goes to FIX.
  - FIX: negates the product or quotient/remainder as required, selects the high or low product half, registers result_o, and goes to DONE.
  - DONE: result_valid_o = 1 for exactly one cycle, then goes to IDLE.
- Latency: with start accepted at cycle 0, result_valid_o = 1 at cycle WIDTH+2 (34 for WIDTH=32).
- stall_o = start_i && !result_valid_o && !flush_i. This is combinational, so it is high in the accept cycle and low in the DONE cycle so the pipeline advances.
- start_i is ignored outside IDLE. A start_i in the DONE cycle belongs to the completing instruction and is not re-accepted.
- result_o holds its last value until the next FIX.
- Multiply:
  - Product is 2*WIDTH bits.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - Product negation applies when the operand signs differ.
- Divide rules:
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Divide by zero: quotient = all ones; remainder = a_i.
  - Signed overflow (a = most-negative value, b = -1): quotient = a_i; remainder = 0.
- Flush: flush_i in any state forces IDLE next cycle. No result_valid_o is generated and result_o is unchanged. flush_i has priority over start_i in the same cycle.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values. No strobe is generated after reset release.

Optional Feature:
MULDIV_FASTPATH_EN
- Defined: in IDLE, divide-by-zero, signed overflow, and multiply with either operand = 0 load the corner result directly and go to DONE. result_valid_o is asserted at cycle 1.
- Undefined: all ops take the full WIDTH+2 cycles. Results are identical; only the latency differs.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; valid at cycle 34; stall_o high on cycles 0-33.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0. With MULDIV_FASTPATH_EN, valid at cycle 1; without it, valid at cycle 34.
- flush_i at cycle 10 of a DIV -> IDLE at cycle 11; no strobe; result_o unchanged. A new MUL 3*4 issued at cycle 12 -> 12 at cycle 46.
- rst_n low at cycle 5 of a MUL -> busy_o and stall_o drop immediately; no strobe after release. start_i held high across the DONE cycle -> exactly one strobe.
